// File: rtl/cal_cmd_driver_pkg.sv
// Shared types and constants for the calculator command driver.
// Command FIFO entry layout, FSM state encoding and calculator drive values.
package cal_cmd_pkg;

  localparam int OPCODE_W = 4;
  localparam int DATA_W   = 32;
  localparam int RESULT_W = 64;

  localparam logic [OPCODE_W-1:0] OP_MUL    = 4'hD;
  localparam logic [DATA_W-1:0]   START_VAL = 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } cmd_t;

  localparam int ENTRY_W = $bits(cmd_t);

endpackage

// File: rtl/cal_cmd_driver_if.sv
// Command stream, result stream and calculator pins of the command driver.
// master = driver side, slave = command source / result sink / calculator.
interface cal_cmd_driver_if;
  import cal_cmd_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [OPCODE_W-1:0] cmd_opcode;
  logic [DATA_W-1:0]   cmd_a;
  logic [DATA_W-1:0]   cmd_b;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [RESULT_W-1:0] rsp_result;
  logic [OPCODE_W-1:0] rsp_opcode;
  logic                rsp_err;

  logic [DATA_W-1:0]   opcode;
  logic [DATA_W-1:0]   opstart;
  logic [DATA_W-1:0]   opclear;
  logic [DATA_W-1:0]   operandA;
  logic [DATA_W-1:0]   operandB;
  logic [RESULT_W-1:0] re;
  logic [RESULT_W-1:0] opdone;

  logic                busy;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready, re, opdone,
    output cmd_ready, rsp_valid, rsp_result, rsp_opcode, rsp_err,
           opcode, opstart, opclear, operandA, operandB, busy
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready, re, opdone,
    input  cmd_ready, rsp_valid, rsp_result, rsp_opcode, rsp_err,
           opcode, opstart, opclear, operandA, operandB, busy
  );

endinterface

// File: rtl/cal_cmd_driver_fifo.sv
// Synchronous command FIFO, DEPTH entries (power of two), head visible when non-empty.
// Latency: pushed entry is at head one cycle later. Push ignored when full, pop ignored when empty.
// Backpressure: full reflects occupancy only; a same-cycle pop does not free a slot for a push.
module cal_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells full (wrap bits differ) from empty (equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/cal_cmd_driver.sv
// Calculator command sequencer: FIFO'd commands -> clear/start calculator -> result stream.
// Latency: 3 edges accept-to-result for a single-cycle op; RUN extends until opdone[0].
// Backpressure: cmd_ready = !full; rsp_ready low holds the FSM in RESP. Timeout: CAL_CMD_DRIVER_TIMEOUT_EN.
module cal_cmd_driver
  import cal_cmd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  cal_cmd_driver_if.master bus
);

  state_e              state;
  cmd_t                push_dat;
  cmd_t                head;
  logic                full;
  logic                empty;
  logic                pop;
  logic                done;

  logic [DATA_W-1:0]   opcode_q;
  logic [DATA_W-1:0]   opstart_q;
  logic [DATA_W-1:0]   opclear_q;
  logic [DATA_W-1:0]   operand_a_q;
  logic [DATA_W-1:0]   operand_b_q;
  logic                rsp_valid_q;
  logic [RESULT_W-1:0] rsp_result_q;
  logic [OPCODE_W-1:0] rsp_opcode_q;
  logic                unused_ok;

  assign push_dat = '{opcode: bus.cmd_opcode, a: bus.cmd_a, b: bus.cmd_b};
  assign pop      = (state == ST_IDLE) && !empty;
  assign done     = bus.opdone[0];

  cal_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (bus.cmd_valid),
    .push_dat (push_dat),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

`ifdef CAL_CMD_DRIVER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] run_cnt;
  logic          rsp_err_q;
  assign bus.rsp_err = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign bus.rsp_err    = 1'b0;
`endif

  assign unused_ok = ^bus.opdone[RESULT_W-1:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      opcode_q     <= '0;
      opstart_q    <= '0;
      opclear_q    <= '0;
      operand_a_q  <= '0;
      operand_b_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_opcode_q <= '0;
`ifdef CAL_CMD_DRIVER_TIMEOUT_EN
      run_cnt      <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            opcode_q    <= {{(DATA_W-OPCODE_W){1'b0}}, head.opcode};
            operand_a_q <= head.a;
            operand_b_q <= head.b;
            opclear_q   <= START_VAL;
            state       <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          opclear_q <= '0;
          opstart_q <= START_VAL;
          state     <= ST_RUN;
`ifdef CAL_CMD_DRIVER_TIMEOUT_EN
          run_cnt   <= '0;
`endif
        end
        ST_RUN: begin
          // re is only valid while opstart is held, so capture here.
          if (done) begin
            rsp_result_q <= bus.re;
            rsp_opcode_q <= opcode_q[OPCODE_W-1:0];
            rsp_valid_q  <= 1'b1;
            opstart_q    <= '0;
            state        <= ST_RESP;
`ifdef CAL_CMD_DRIVER_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
          end else if (run_cnt == TO_LAST) begin
            rsp_result_q <= '0;
            rsp_opcode_q <= opcode_q[OPCODE_W-1:0];
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            opstart_q    <= '0;
            state        <= ST_RESP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.opcode     = opcode_q;
  assign bus.opstart    = opstart_q;
  assign bus.opclear    = opclear_q;
  assign bus.operandA   = operand_a_q;
  assign bus.operandB   = operand_b_q;
  assign bus.busy       = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_cal_cmd_driver.sv
// Directed bench for cal_cmd_driver with a behavioural calculator responder.
// Multiply finishes mul_delay RUN cycles after entering RUN; other opcodes finish at once (re = A+B).
module tb_cal_cmd_driver;
  import cal_cmd_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  int   run_cnt = 0;
  int   mul_delay = 32;
  bit   never_done = 1'b0;
  int   edges;

  cal_cmd_driver_if bus();

  cal_cmd_driver #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Calculator model: opclear resets the cycle count, re is zero unless started.
  always @(posedge clk) begin
    if (bus.opclear != 32'd0) run_cnt <= 0;
    else if (bus.opstart == 32'd1) run_cnt <= run_cnt + 1;
  end

  always_comb begin
    logic on;
    logic is_mul;
    on = (bus.opstart == 32'd1);
    is_mul = (bus.opcode == 32'hD);
    bus.opdone = '0;
    bus.opdone[0] = on && !never_done && (run_cnt >= (is_mul ? mul_delay : 0));
    bus.re = '0;
    if (on)
      bus.re = is_mul ? ({32'd0, bus.operandA} * {32'd0, bus.operandB})
                      : ({32'd0, bus.operandA} + {32'd0, bus.operandB});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    chk("cmd_ready_at_push", bus.cmd_ready, 1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output int n);
    n = 0;
    while (!bus.rsp_valid && n < limit) begin
      step();
      n++;
    end
    chk("rsp_within_budget", bus.rsp_valid, 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_opstart", bus.opstart, 0);
    chk("rst_opclear", bus.opclear, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    #20 reset_n = 1'b1;
    step();

    // ALU command: 3 edges accept-to-result, one CLEAR cycle before RUN
    push(4'h1, 32'd7, 32'd5);
    chk("alu_e0_opclear", bus.opclear, 0);
    chk("alu_e0_busy", bus.busy, 1);
    step();
    chk("alu_e1_opclear", bus.opclear, 1);
    chk("alu_e1_opstart", bus.opstart, 0);
    chk("alu_e1_opcode", bus.opcode, 1);
    chk("alu_e1_operandA", bus.operandA, 7);
    chk("alu_e1_operandB", bus.operandB, 5);
    step();
    chk("alu_e2_opclear", bus.opclear, 0);
    chk("alu_e2_opstart", bus.opstart, 1);
    chk("alu_e2_rsp_valid", bus.rsp_valid, 0);
    step();
    chk("alu_e3_rsp_valid", bus.rsp_valid, 1);
    chk("alu_e3_result", bus.rsp_result, 64'hC);
    chk("alu_e3_rsp_opcode", bus.rsp_opcode, 4'h1);
    chk("alu_e3_rsp_err", bus.rsp_err, 0);
    chk("alu_e3_opstart", bus.opstart, 0);
    step();
    chk("alu_e4_rsp_valid", bus.rsp_valid, 0);
    chk("alu_e4_busy", bus.busy, 0);

    // Multiply: done after 32 extra RUN cycles, latency 35
    mul_delay = 32;
    push(OP_MUL, 32'hFFFF_FFFF, 32'd2);
    wait_rsp(100, edges);
    chk("mul_latency", 64'(edges), 35);
    chk("mul_result", bus.rsp_result, 64'h1_FFFF_FFFE);
    chk("mul_rsp_opcode", bus.rsp_opcode, 4'hD);
    step();

    // Fill FIFO with responses stalled: 4 queued + 1 in flight
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(4'h2, 32'(10 + i), 32'd100);
    chk("fill_cmd_ready_low", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_opcode = 4'h2;
    bus.cmd_a = 32'd999;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_stays_full", bus.cmd_ready, 0);
    end
    bus.cmd_valid = 1'b0;
    chk("stall_rsp_valid", bus.rsp_valid, 1);
    chk("stall_rsp_result", bus.rsp_result, 64'd110);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(20, edges);
      chk("drain_spacing", 64'(edges), (k == 0) ? 0 : 3);
      chk("drain_result", bus.rsp_result, 64'(110 + k));
      chk("drain_opcode", bus.rsp_opcode, 4'h2);
      step();
    end
    for (int i = 0; i < 6; i++) step();
    chk("drain_no_extra", bus.rsp_valid, 0);
    chk("drain_idle", bus.busy, 0);
    chk("drain_cmd_ready", bus.cmd_ready, 1);

    // Calculator never completes
    never_done = 1'b1;
    push(4'h3, 32'd1, 32'd1);
`ifdef CAL_CMD_DRIVER_TIMEOUT_EN
    wait_rsp(200, edges);
    chk("to_latency", 64'(edges), 66);
    chk("to_err", bus.rsp_err, 1);
    chk("to_result", bus.rsp_result, 0);
    chk("to_opstart", bus.opstart, 0);
    chk("to_opcode", bus.rsp_opcode, 4'h3);
    step();
    chk("to_idle", bus.busy, 0);
`else
    for (int i = 0; i < 1000; i++) step();
    chk("hang_opstart", bus.opstart, 1);
    chk("hang_rsp_valid", bus.rsp_valid, 0);
    chk("hang_err", bus.rsp_err, 0);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    step();
`endif
    never_done = 1'b0;

    // Async reset during a multiply RUN
    mul_delay = 32;
    push(OP_MUL, 32'd6, 32'd7);
    for (int i = 0; i < 10; i++) step();
    chk("pre_rst_opstart", bus.opstart, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_opstart", bus.opstart, 0);
    chk("arst_opcode", bus.opcode, 0);
    chk("arst_operandA", bus.operandA, 0);
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("post_rst_no_rsp", bus.rsp_valid, 0);
    push(4'h1, 32'd3, 32'd4);
    wait_rsp(20, edges);
    chk("post_rst_latency", 64'(edges), 3);
    chk("post_rst_result", bus.rsp_result, 64'd7);
    step();

    // Done coincides with the 64th RUN cycle
    mul_delay = 63;
    push(OP_MUL, 32'd3, 32'd5);
    wait_rsp(200, edges);
    chk("tie_latency", 64'(edges), 66);
    chk("tie_err", bus.rsp_err, 0);
    chk("tie_result", bus.rsp_result, 64'hF);
    step();
    chk("tie_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
